mant_mul_seq: RTL and testbench
===============================

Name: mant_mul_seq

Overview:
- Multi-cycle shift-and-add sequencer for FP16 significand multiplication in the MAC unit.
- Takes two WIDTH-bit significands with the hidden bit included, and returns their 2*WIDTH-bit product.
- Time-multiplexes one WIDTH-bit ripple adder over WIDTH cycles.
- Sits between operand unpacking and normalisation/rounding; valid/ready on both sides.

Parameters:
- WIDTH, 11, significand width including hidden bit; product width is 2*WIDTH.
- ZERO_SKIP, 1, when 1 a zero operand bypasses iteration and goes straight to DONE.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a_mant  input  WIDTH  multiplicand, sampled on accept.
- b_mant  input  WIDTH  multiplier, sampled on accept.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a_mant*b_mant, unsigned.
- busy  output  1  high in RUN.

Behaviour:
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - product=0, internal accumulator=0, step counter=0.
- States: IDLE, RUN, DONE. Encoding is free.
- Accept: in IDLE with in_valid=1, capture a_mant into mcand and b_mant into the low half of acc. Clear the high half of acc and the step counter.
  - With ZERO_SKIP=1 and either operand 0: go to DONE with acc=0.
  - Otherwise go to RUN.
- RUN, one step per clock:
  - If acc[0]=1: {carry, sum} = acc[2W-1:W] + mcand. Otherwise {carry, sum} = {0, acc[2W-1:W]}.
  - acc <= {carry, sum, acc[W-1:1]}, a right shift by 1 that brings in the adder carry.
  - Counter increments.
  - After the step with counter=WIDTH-1, go to DONE.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge, or 1 edge when zero-skipped.
- DONE:
  - product = acc, held stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE. out_valid falls on that edge.
- No overlap: in_ready=0 in RUN and DONE.
  - in_valid asserted outside IDLE is ignored and not queued.
  - Operand inputs are don't-care after accept.
- Throughput: one product per WIDTH+2 cycles with out_ready tied high.
- Adder width: WIDTH-bit operands, 1-bit carry-out, carry-in tied 0. The carry must never be dropped; it becomes acc[2W-1] after the shift.
- Result range: the maximum product (2^W-1)^2 fits in 2*WIDTH bits, so no overflow flag is needed.
- product is registered; it is the acc register, and its value is only meaningful while out_valid=1.
- Reset mid-operation: asynchronous return to IDLE, all outputs to reset values, partial result discarded.
- Simultaneous in_valid and out_ready in DONE: only the DONE->IDLE exit occurs. The new operand is accepted on the following edge at the earliest.

Decomposition:
- Shared package holds:
  - FP16 field constants: MANT_W=10, SIG_W=11, EXP_W=5.
  - The 3-state encoding typedef.
- Sub-module mant_adder:
  - Combinational WIDTH-bit unsigned adder with cin and cout, built from full-adder cells.
  - Instantiated once; all arithmetic goes through it.
- The FSM, counter and accumulator stay in mant_mul_seq.

Test Plan:
- 1.0*1.0: a=0x400, b=0x400 -> out_valid 11 edges after accept, product=0x100000.
- 1.5*1.5: a=0x600, b=0x600 -> product=0x240000.
- Max-operand carry check: a=0x7FF, b=0x7FF -> product=0x3FF001.
- Zero skip: a=0x000, b=0x5A5 -> out_valid after 1 edge, product=0. With ZERO_SKIP=0 -> after 11 edges, product=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - product and out_valid hold, in_ready stays 0.
  - in_valid pulses during RUN/DONE are ignored.
  - Release -> IDLE next edge.
- Reset mid-RUN: assert rst at step 4 -> immediate IDLE, out_valid=0, product=0. A fresh 0x7FF*0x400 then yields 0x1FFC00.
- Back-to-back: 20 random pairs with out_ready=1 -> every product matches the reference multiply, spacing is WIDTH+2 cycles, no lost or duplicated results.

Source files
------------

// File: rtl/mant_mul_seq_pkg.sv
// Shared FP16 field widths and sequencer state encoding for the MAC significand path.
package mant_mul_seq_pkg;

  localparam int unsigned MANT_W = 10;
  localparam int unsigned SIG_W  = 11;
  localparam int unsigned EXP_W  = 5;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/mant_adder.sv
// Combinational unsigned ripple adder built from full-adder cells.
module mant_adder #(
  parameter int unsigned WIDTH = 11
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mant_mul_seq.sv
// Shift-and-add significand multiplier: one shared WIDTH-bit adder, one step per clock.
module mant_mul_seq
  import mant_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = SIG_W,
  parameter bit          ZERO_SKIP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_mant,
  input  logic [WIDTH-1:0]     b_mant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic                 zero_op;

  // Multiplier bit in acc[0] gates the multiplicand into the adder.
  assign add_b = acc_q[0] ? mcand_q : '0;

  mant_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (acc_q[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign zero_op = ZERO_SKIP && ((a_mant == '0) || (b_mant == '0));

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d = a_mant;
          cnt_d   = '0;
          if (zero_op) begin
            acc_d   = '0;
            state_d = StDone;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, b_mant};
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Adder carry shifts in at the top so the full product fits in 2*WIDTH bits.
        acc_d = {add_cout, add_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun);
  assign product   = acc_q;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed bench for mant_mul_seq: known products, latency, backpressure, reset and streaming.
module tb_mant_mul_seq;

  localparam int W = 11;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   a_mant, b_mant;
  logic [2*W-1:0] product;

  logic           nz_in_valid, nz_in_ready, nz_out_valid, nz_out_ready, nz_busy;
  logic [W-1:0]   nz_a, nz_b;
  logic [2*W-1:0] nz_product;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mant_mul_seq #(.WIDTH(W), .ZERO_SKIP(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  mant_mul_seq #(.WIDTH(W), .ZERO_SKIP(1'b0)) u_dut_nz (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (nz_in_valid),
    .in_ready  (nz_in_ready),
    .a_mant    (nz_a),
    .b_mant    (nz_b),
    .out_valid (nz_out_valid),
    .out_ready (nz_out_ready),
    .product   (nz_product),
    .busy      (nz_busy)
  );

  // Accept one operand pair on the main DUT; lat = edges after the accepting edge until out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] prod, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    a_mant = a; b_mant = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_mant = '1; b_mant = '1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    prod = product;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_mant = '0; b_mant = '0;
    nz_in_valid = 1'b0; nz_out_ready = 1'b1; nz_a = '0; nz_b = '0;
    #12;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL reset_flags: got %b want 100", {in_ready, out_valid, busy});
    end
    checks++;
    if (product !== '0) begin
      errors++; $display("FAIL reset_product: got %h want 0", product);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL idle_after_reset: got %b want 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_products;
    logic [W-1:0]   ta [3] = '{11'h400, 11'h600, 11'h7FF};
    logic [W-1:0]   tb [3] = '{11'h400, 11'h600, 11'h7FF};
    logic [2*W-1:0] te [3] = '{22'h100000, 22'h240000, 22'h3FF001};
    logic [2*W-1:0] p;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], p, lat);
      checks++;
      if (p !== te[i]) begin
        errors++; $display("FAIL product_%0d: got %h want %h", i, p, te[i]);
      end
      checks++;
      if (lat != W) begin
        errors++; $display("FAIL latency_%0d: got %0d want %0d", i, lat, W);
      end
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++; $display("FAIL exit_%0d: got %b want 10", i, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_zero_skip;
    logic [2*W-1:0] p;
    int lat;
    out_ready = 1'b1;
    run_op(11'h000, 11'h5A5, p, lat);
    checks++;
    if (p !== '0 || lat != 0) begin
      errors++; $display("FAIL zero_a: got prod %h lat %0d want 0 lat 0", p, lat);
    end
    @(posedge clk); #1;
    run_op(11'h3FF, 11'h000, p, lat);
    checks++;
    if (p !== '0 || lat != 0) begin
      errors++; $display("FAIL zero_b: got prod %h lat %0d want 0 lat 0", p, lat);
    end
    @(posedge clk); #1;
    // Same operands on the non-skipping instance must iterate the full WIDTH steps.
    nz_a = 11'h000; nz_b = 11'h5A5; nz_in_valid = 1'b1;
    @(posedge clk); #1;
    nz_in_valid = 1'b0;
    lat = 0;
    while (!nz_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (nz_product !== '0 || lat != W) begin
      errors++; $display("FAIL zero_noskip: got prod %h lat %0d want 0 lat %0d",
                         nz_product, lat, W);
    end
  endtask

  task automatic test_backpressure;
    logic [2*W-1:0] p;
    int lat;
    out_ready = 1'b0;
    a_mant = 11'h600; b_mant = 11'h400; in_valid = 1'b1;
    @(posedge clk); #1;
    a_mant = 11'h7FF; b_mant = 11'h7FF;
    // Keep in_valid high through RUN with different operands; it must be ignored.
    lat = 0;
    while (!out_valid && lat < 100) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL run_flags: got ready %b busy %b want 0 1", in_ready, busy);
      end
      @(posedge clk); #1; lat++;
    end
    p = product;
    checks++;
    if (p !== 22'h180000 || lat != W) begin
      errors++; $display("FAIL bp_product: got %h lat %0d want 180000 lat %0d", p, lat, W);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b100 || product !== 22'h180000) begin
        errors++; $display("FAIL bp_hold_%0d: got flags %b prod %h want 100 180000",
                           i, {out_valid, in_ready, busy}, product);
      end
    end
    // Release with in_valid still high: only the exit to IDLE may happen on this edge.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL bp_release: got %b want 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_reset_mid_run;
    logic [2*W-1:0] p;
    int lat;
    out_ready = 1'b1;
    a_mant = 11'h7FF; b_mant = 11'h7FF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || product !== '0) begin
      errors++; $display("FAIL mid_reset: got flags %b prod %h want 100 0",
                         {in_ready, out_valid, busy}, product);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_op(11'h7FF, 11'h400, p, lat);
    checks++;
    if (p !== 22'h1FFC00 || lat != W) begin
      errors++; $display("FAIL after_reset_op: got %h lat %0d want 1ffc00 lat %0d", p, lat, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] exp_p;
    int prev_acc, results, guard;
    results = 0; prev_acc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(1, 2047));
      rb = W'($urandom_range(1, 2047));
      exp_p = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
      a_mant = ra; b_mant = rb;
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(posedge clk); #1; guard++;
        checks++;
        if (out_valid !== 1'b0 && in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_overlap_%0d: out_valid and in_ready both high", i);
        end
      end
      @(posedge clk); #1;
      if (i > 0) begin
        checks++;
        if (cyc - prev_acc != W + 2) begin
          errors++; $display("FAIL b2b_spacing_%0d: got %0d want %0d", i, cyc - prev_acc, W + 2);
        end
      end
      prev_acc = cyc;
      a_mant = '0; b_mant = '0;
      guard = 0;
      while (!out_valid && guard < 100) begin
        @(posedge clk); #1; guard++;
      end
      if (out_valid) results++;
      checks++;
      if (product !== exp_p) begin
        errors++; $display("FAIL b2b_product_%0d: got %h want %h (%h*%h)", i, product, exp_p, ra, rb);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_dup_%0d: out_valid got %b want 0", i, out_valid);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (results != 20) begin
      errors++; $display("FAIL b2b_count: got %0d want 20", results);
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_zero_skip();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
